// File: rtl/sobel_window_ctrl.sv
// sobel_window_ctrl: sequencing controller for the Sobel line-buffer chain.
// Accepts a raster pixel stream and drives the shared line-buffer Enable.
// It tracks the column and row of the next pixel. It flags a valid 3x3 window,
// and it applies kernel backpressure to the pixel source.
// Optional feature: define SOBEL_CTRL_ERRCNT_EN to add the ErrCount output.
// ErrCount is a saturating count of SOFs that arrive mid-frame.

module sobel_window_ctrl #(
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64,
    parameter int DATA_W     = 8
) (
    input  logic                          CLK,
    input  logic                          RST_n,
    input  logic                          PixelValid,
    input  logic                          PixelSOF,
    input  logic [DATA_W-1:0]             PixelIn,
    output logic                          PixelReady,
    output logic                          Enable,
    output logic [DATA_W-1:0]             BufDataIn,
    output logic                          WinValid,
    input  logic                          WinReady,
    output logic [$clog2(IMG_WIDTH)-1:0]  WinCol,
    output logic [$clog2(IMG_HEIGHT)-1:0] WinRow,
    output logic                          FrameDone
`ifdef SOBEL_CTRL_ERRCNT_EN
    ,
    output logic [7:0]                    ErrCount
`endif
);

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        STREAM,
        DONE
    } ctrlStateT;

    ctrlStateT        state;
    ctrlStateT        nextState;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;

    logic accept;
    logic sofAccept;
    logic pixAdvance;
    logic lastPixel;
    logic newWin;

    // PixelReady is forced low while reset is asserted.
    // It is also low in DONE and whenever a window is held against the kernel.
    assign PixelReady = RST_n & (state != DONE) & ~(WinValid & ~WinReady);
    assign accept     = PixelValid & PixelReady;
    // The buffers shift on the same edge as the accept.
    // A non-SOF pixel seen in IDLE is dropped.
    assign Enable     = accept & ((state != IDLE) | PixelSOF);
    assign BufDataIn  = PixelIn;
    assign FrameDone  = (state == DONE);

    // An SOF restarts the frame from any accepting state.
    // A plain pixel only counts once a frame is in progress.
    assign sofAccept  = accept & PixelSOF;
    assign pixAdvance = accept & ~PixelSOF & ((state == PRIME) | (state == STREAM));
    assign lastPixel  = (col == LAST_COL) & (row == LAST_ROW);
    assign newWin     = pixAdvance & (row >= ROW_W'(2)) & (col >= COL_W'(2));

    // State register.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state <= IDLE;
        end else begin
            // NOTE: clocked blocks use <= so every register samples pre-edge values.
            state <= nextState;
        end
    end

    // Next-state decode.
    always_comb begin
        // NOTE: default first so no path leaves nextState unassigned (no latch).
        nextState = state;
        unique case (state)
            IDLE: begin
                if (sofAccept) nextState = PRIME;
            end
            PRIME: begin
                if (sofAccept)                                         nextState = PRIME;
                else if (pixAdvance && lastPixel)                      nextState = DONE;
                else if (pixAdvance && row == ROW_W'(2) && col == COL_W'(2)) nextState = STREAM;
            end
            STREAM: begin
                if (sofAccept)                    nextState = PRIME;
                else if (pixAdvance && lastPixel) nextState = DONE;
            end
            DONE: begin
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Position of the next accepted pixel; an SOF pixel occupies (0,0).
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            col <= '0;
            row <= '0;
        end else if (sofAccept) begin
            col <= COL_W'(1);
            row <= '0;
        end else if (pixAdvance) begin
            if (col == LAST_COL) begin
                col <= '0;
                row <= (row == LAST_ROW) ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    // Window flag and centre position.
    // They hold until the kernel takes the window, and an SOF drops them.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            WinValid <= 1'b0;
            WinCol   <= '0;
            WinRow   <= '0;
        end else if (sofAccept) begin
            WinValid <= 1'b0;
        end else if (newWin) begin
            WinValid <= 1'b1;
            WinCol   <= col - COL_W'(1);
            WinRow   <= row - ROW_W'(1);
        end else if (WinReady) begin
            WinValid <= 1'b0;
        end
    end

`ifdef SOBEL_CTRL_ERRCNT_EN
    // Saturating count of SOFs that arrive mid-frame (the SOF in IDLE is normal).
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            ErrCount <= '0;
        end else if (sofAccept && state != IDLE && ErrCount != 8'hFF) begin
            ErrCount <= ErrCount + 8'd1;
        end
    end
`endif

endmodule
